dsp_top_slice: RTL and testbench

DSP_TOP_SLICE -- requirements
Module: dsp_top_slice

---
 rtl/dsp_top_slice_pkg.sv | 61 ++++++
 rtl/dsp_pipe_reg.sv | 32 +++
 rtl/dsp_top_slice.sv | 219 +++++++++++++++++++++
 tb/tb_dsp_top_slice.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dsp_top_slice_pkg.sv
// Shared encodings and widths for the DSP slice: operand widths, OPMODE X/Y/Z
// multiplexer codes, ALUMODE operations and CARRYINSEL sources.
package dsp_top_slice_pkg;

   localparam int A_W  = 30;
   localparam int B_W  = 18;
   localparam int C_W  = 48;
   localparam int D_W  = 25;
   localparam int AD_W = 25;
   localparam int M_W  = 43;
   localparam int P_W  = 48;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_AB   = 2'b11
   } opmode_x_e;

   typedef enum logic [1:0] {
      Y_ZERO  = 2'b00,
      Y_MZERO = 2'b01,
      Y_ONES  = 2'b10,
      Y_C     = 2'b11
   } opmode_y_e;

   typedef enum logic [2:0] {
      Z_ZERO  = 3'b000,
      Z_PIN   = 3'b001,
      Z_P     = 3'b010,
      Z_C     = 3'b011,
      Z_P2    = 3'b100,
      Z_PIN17 = 3'b101,
      Z_P17   = 3'b110,
      Z_ZERO7 = 3'b111
   } opmode_z_e;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000,
      ALU_NZADD  = 4'b0001,
      ALU_NOTADD = 4'b0010,
      ALU_ZSUB   = 4'b0011,
      ALU_XOR    = 4'b0100,
      ALU_XNOR   = 4'b0101,
      ALU_AND    = 4'b1100,
      ALU_ANDN   = 4'b1101,
      ALU_OR     = 4'b1110,
      ALU_NOR    = 4'b1111
   } alumode_e;

   typedef enum logic [2:0] {
      CIN_FABRIC = 3'b000,
      CIN_CASC   = 3'b010,
      CIN_ROUND  = 3'b111
   } carryinsel_e;

   function automatic logic [P_W-1:0] sext_m(input logic [M_W-1:0] m);
      return {{(P_W-M_W){m[M_W-1]}}, m};
   endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic slice register: CE-gated, asynchronously reset to zero, or a plain
// wire when EN is 0 so one instance covers every configurable pipeline depth.
module dsp_pipe_reg #(
   parameter int W  = 1,
   parameter bit EN = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ce_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (EN) begin : g_reg
         logic [W-1:0] data_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               data_q <= '0;
            end else if (ce_i) begin
               data_q <= d_i;
            end
         end
         assign q_o = data_q;
      end else begin : g_byp
         logic unused_w;
         assign unused_w = ^{clk_i, rst_i, ce_i};
         assign q_o      = d_i;
      end
   endgenerate

endmodule

// File: rtl/dsp_top_slice.sv
// DSP slice: registered A/B/C/D inputs, D+-A pre-adder, 25x18 multiplier,
// X/Y/Z-fed 48-bit ALU with carry select, P register and pattern detector.
module dsp_top_slice
   import dsp_top_slice_pkg::*;
#(
   parameter int          AREG        = 1,
   parameter int          BREG        = 1,
   parameter int          CREG        = 1,
   parameter int          DREG        = 1,
   parameter int          ADREG       = 1,
   parameter int          MREG        = 1,
   parameter int          PREG        = 1,
   parameter int          CTRLREG     = 1,
   parameter int          ALUMODEREG  = 1,
   parameter int          INMODEREG   = 1,
   parameter int          CARRYINREG  = 1,
   parameter int          SEL_PATTERN = 0,
   parameter logic [47:0] PATTERN     = 48'h0,
   parameter logic [47:0] MASK        = 48'h0
) (
   input  logic           CLK,
   input  logic           RSTA,
   input  logic           RSTB,
   input  logic           RSTC,
   input  logic           RSTD,
   input  logic           RSTM,
   input  logic           RSTP,
   input  logic           RSTCTRL,
   input  logic           RSTALLCARRYIN,
   input  logic           RSTALUMODE,
   input  logic           RSTINMODE,
   input  logic           CEA1,
   input  logic           CEA2,
   input  logic           CEB1,
   input  logic           CEB2,
   input  logic           CEC,
   input  logic           CED,
   input  logic           CEAD,
   input  logic           CEM,
   input  logic           CEP,
   input  logic           CECTRL,
   input  logic           CEALUMODE,
   input  logic           CECARRYIN,
   input  logic           CEINMODE,
   input  logic [A_W-1:0] A,
   input  logic [B_W-1:0] B,
   input  logic [C_W-1:0] C,
   input  logic [D_W-1:0] D,
   input  logic [A_W-1:0] ACIN,
   input  logic [B_W-1:0] BCIN,
   input  logic [P_W-1:0] PIN,
   input  logic           CARRYCASCIN,
   input  logic           MULTSIGNIN,
   input  logic [4:0]     INMODE,
   input  logic [6:0]     OPMODE,
   input  logic [3:0]     ALUMODE,
   input  logic [2:0]     CARRYINSEL,
   input  logic           CARRYIN,
   output logic [P_W-1:0] P,
   output logic [P_W-1:0] PCOUT,
   output logic [A_W-1:0] ACOUT,
   output logic [B_W-1:0] BCOUT,
   output logic           CARRYOUT,
   output logic           CARRYCASCOUT,
   output logic           MULTSIGNOUT,
   output logic           PATTERN_DETECT,
   output logic           PATTERNB_DETECT
);

   localparam int PB_W = P_W + 4;

   logic [A_W-1:0]  a1_q, a2_q;
   logic [B_W-1:0]  b1_q, b2_q;
   logic [C_W-1:0]  c_q;
   logic [D_W-1:0]  d_q;
   logic [4:0]      inmode_q;
   logic [9:0]      ctrl_q;
   logic [3:0]      alumode_q;
   logic            carryin_q;
   logic [AD_W-1:0] a_mult, ad_d, ad_q;
   logic [B_W-1:0]  b_mult;
   logic [M_W-1:0]  m_full;
   logic [P_W-1:0]  m_d, m_q;
   logic [P_W-1:0]  x_mux, y_mux, z_mux, alu_res, pat;
   logic [P_W:0]    alu_sum;
   logic            cin, alu_carry;
   logic [PB_W-1:0] pb_d, pb_q;
   logic            unused_w;

   opmode_x_e   x_sel;
   opmode_y_e   y_sel;
   opmode_z_e   z_sel;
   alumode_e    alu_sel;
   carryinsel_e cin_sel;

   // Input stage: A/B two-deep chains, C, D and control registers
   dsp_pipe_reg #(.W(A_W), .EN(AREG == 2)) u_a1 (.clk_i(CLK), .rst_i(RSTA), .ce_i(CEA1), .d_i(A),    .q_o(a1_q));
   dsp_pipe_reg #(.W(A_W), .EN(AREG >= 1)) u_a2 (.clk_i(CLK), .rst_i(RSTA), .ce_i(CEA2), .d_i(a1_q), .q_o(a2_q));
   dsp_pipe_reg #(.W(B_W), .EN(BREG == 2)) u_b1 (.clk_i(CLK), .rst_i(RSTB), .ce_i(CEB1), .d_i(B),    .q_o(b1_q));
   dsp_pipe_reg #(.W(B_W), .EN(BREG >= 1)) u_b2 (.clk_i(CLK), .rst_i(RSTB), .ce_i(CEB2), .d_i(b1_q), .q_o(b2_q));
   dsp_pipe_reg #(.W(C_W), .EN(CREG != 0)) u_c  (.clk_i(CLK), .rst_i(RSTC), .ce_i(CEC),  .d_i(C),    .q_o(c_q));
   dsp_pipe_reg #(.W(D_W), .EN(DREG != 0)) u_d  (.clk_i(CLK), .rst_i(RSTD), .ce_i(CED),  .d_i(D),    .q_o(d_q));

   dsp_pipe_reg #(.W(5), .EN(INMODEREG != 0)) u_inmode (
      .clk_i(CLK), .rst_i(RSTINMODE), .ce_i(CEINMODE), .d_i(INMODE), .q_o(inmode_q));
   dsp_pipe_reg #(.W(10), .EN(CTRLREG != 0)) u_ctrl (
      .clk_i(CLK), .rst_i(RSTCTRL), .ce_i(CECTRL), .d_i({CARRYINSEL, OPMODE}), .q_o(ctrl_q));
   dsp_pipe_reg #(.W(4), .EN(ALUMODEREG != 0)) u_alumode (
      .clk_i(CLK), .rst_i(RSTALUMODE), .ce_i(CEALUMODE), .d_i(ALUMODE), .q_o(alumode_q));
   dsp_pipe_reg #(.W(1), .EN(CARRYINREG != 0)) u_carryin (
      .clk_i(CLK), .rst_i(RSTALLCARRYIN), .ce_i(CECARRYIN), .d_i(CARRYIN), .q_o(carryin_q));

   assign x_sel   = opmode_x_e'(ctrl_q[1:0]);
   assign y_sel   = opmode_y_e'(ctrl_q[3:2]);
   assign z_sel   = opmode_z_e'(ctrl_q[6:4]);
   assign cin_sel = carryinsel_e'(ctrl_q[9:7]);
   assign alu_sel = alumode_e'(alumode_q);

   // Pre-adder stage
   always_comb begin
      a_mult = inmode_q[1] ? '0 : a2_q[AD_W-1:0];
      ad_d   = a_mult;
      if (inmode_q[2]) begin
         ad_d = inmode_q[3] ? (d_q - a_mult) : (d_q + a_mult);
      end
   end

   dsp_pipe_reg #(.W(AD_W), .EN(ADREG != 0)) u_ad (
      .clk_i(CLK), .rst_i(RSTD), .ce_i(CEAD), .d_i(ad_d), .q_o(ad_q));

   // Multiplier stage; the low 43 bits of the sign-extended product are exact
   assign b_mult = inmode_q[4] ? b1_q : b2_q;
   assign m_full = {{(M_W-AD_W){ad_q[AD_W-1]}}, ad_q} * {{(M_W-B_W){b_mult[B_W-1]}}, b_mult};
   assign m_d    = sext_m(m_full);

   dsp_pipe_reg #(.W(P_W), .EN(MREG != 0)) u_m (
      .clk_i(CLK), .rst_i(RSTM), .ce_i(CEM), .d_i(m_d), .q_o(m_q));

   // ALU stage
   always_comb begin
      case (x_sel)
         X_M:     x_mux = m_q;
         X_P:     x_mux = P;
         X_AB:    x_mux = {a2_q, b2_q};
         default: x_mux = '0;
      endcase
      case (y_sel)
         Y_ONES:  y_mux = '1;
         Y_C:     y_mux = c_q;
         default: y_mux = '0;
      endcase
      case (z_sel)
         Z_PIN:        z_mux = PIN;
         Z_P, Z_P2:    z_mux = P;
         Z_C:          z_mux = c_q;
         Z_PIN17:      z_mux = $signed(PIN) >>> 17;
         Z_P17:        z_mux = $signed(P) >>> 17;
         default:      z_mux = '0;
      endcase
      case (cin_sel)
         CIN_FABRIC: cin = carryin_q;
         CIN_CASC:   cin = CARRYCASCIN;
         CIN_ROUND:  cin = ~m_q[P_W-1];
         default:    cin = 1'b0;
      endcase
   end

   always_comb begin
      alu_sum   = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      case (alu_sel)
         ALU_ADD, ALU_NOTADD: alu_sum = {1'b0, z_mux} + {1'b0, x_mux} + {1'b0, y_mux} + {{P_W{1'b0}}, cin};
         ALU_NZADD:           alu_sum = {1'b0, ~z_mux} + {1'b0, x_mux} + {1'b0, y_mux} + {{P_W{1'b0}}, cin};
         ALU_ZSUB:            alu_sum = {1'b0, z_mux} - {1'b0, x_mux} - {1'b0, y_mux} - {{P_W{1'b0}}, cin};
         default:             alu_sum = '0;
      endcase
      case (alu_sel)
         ALU_ADD, ALU_NZADD, ALU_ZSUB: begin
            alu_res   = alu_sum[P_W-1:0];
            alu_carry = alu_sum[P_W];
         end
         ALU_NOTADD: begin
            alu_res   = ~alu_sum[P_W-1:0];
            alu_carry = alu_sum[P_W];
         end
         ALU_XOR:  alu_res = x_mux ^ z_mux;
         ALU_XNOR: alu_res = ~(x_mux ^ z_mux);
         ALU_AND:  alu_res = x_mux & z_mux;
         ALU_ANDN: alu_res = x_mux & ~z_mux;
         ALU_OR:   alu_res = x_mux | z_mux;
         ALU_NOR:  alu_res = ~(x_mux | z_mux);
         default:  alu_res = '0;
      endcase
   end

   // Output stage: flags share the P register so they stay aligned with P
   assign pat  = (SEL_PATTERN != 0) ? PATTERN : c_q;
   assign pb_d = {alu_carry, m_q[P_W-1],
                  (((alu_res ^ ~pat) & ~MASK) == '0),
                  (((alu_res ^ pat) & ~MASK) == '0),
                  alu_res};

   dsp_pipe_reg #(.W(PB_W), .EN(PREG != 0)) u_p (
      .clk_i(CLK), .rst_i(RSTP), .ce_i(CEP), .d_i(pb_d), .q_o(pb_q));

   assign P               = pb_q[P_W-1:0];
   assign PCOUT           = P;
   assign PATTERN_DETECT  = pb_q[P_W];
   assign PATTERNB_DETECT = pb_q[P_W+1];
   assign MULTSIGNOUT     = pb_q[P_W+2];
   assign CARRYOUT        = pb_q[P_W+3];
   assign CARRYCASCOUT    = pb_q[P_W+3];
   assign ACOUT           = a2_q;
   assign BCOUT           = b2_q;

   assign unused_w = ^{ACIN, BCIN, MULTSIGNIN, inmode_q[0]};

endmodule

// File: tb/tb_dsp_top_slice.sv
// Directed bench for dsp_top_slice with hand-computed expected values.
module tb_dsp_top_slice;

   logic        CLK = 1'b0;
   logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCTRL, RSTALLCARRYIN, RSTALUMODE, RSTINMODE;
   logic        CEA1, CEA2, CEB1, CEB2, CEC, CED, CEAD, CEM, CEP, CECTRL, CEALUMODE, CECARRYIN, CEINMODE;
   logic [29:0] A, ACIN, ACOUT;
   logic [17:0] B, BCIN, BCOUT;
   logic [47:0] C, PIN, P, PCOUT;
   logic [24:0] D;
   logic        CARRYCASCIN, MULTSIGNIN, CARRYIN;
   logic [4:0]  INMODE;
   logic [6:0]  OPMODE;
   logic [3:0]  ALUMODE;
   logic [2:0]  CARRYINSEL;
   logic        CARRYOUT, CARRYCASCOUT, MULTSIGNOUT, PATTERN_DETECT, PATTERNB_DETECT;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   dsp_top_slice dut (
      .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
      .RSTCTRL(RSTCTRL), .RSTALLCARRYIN(RSTALLCARRYIN), .RSTALUMODE(RSTALUMODE), .RSTINMODE(RSTINMODE),
      .CEA1(CEA1), .CEA2(CEA2), .CEB1(CEB1), .CEB2(CEB2), .CEC(CEC), .CED(CED), .CEAD(CEAD),
      .CEM(CEM), .CEP(CEP), .CECTRL(CECTRL), .CEALUMODE(CEALUMODE), .CECARRYIN(CECARRYIN),
      .CEINMODE(CEINMODE), .A(A), .B(B), .C(C), .D(D), .ACIN(ACIN), .BCIN(BCIN), .PIN(PIN),
      .CARRYCASCIN(CARRYCASCIN), .MULTSIGNIN(MULTSIGNIN), .INMODE(INMODE), .OPMODE(OPMODE),
      .ALUMODE(ALUMODE), .CARRYINSEL(CARRYINSEL), .CARRYIN(CARRYIN), .P(P), .PCOUT(PCOUT),
      .ACOUT(ACOUT), .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYCASCOUT(CARRYCASCOUT),
      .MULTSIGNOUT(MULTSIGNOUT), .PATTERN_DETECT(PATTERN_DETECT), .PATTERNB_DETECT(PATTERNB_DETECT)
   );

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_rst(input logic v);
      {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCTRL, RSTALLCARRYIN, RSTALUMODE, RSTINMODE} = {10{v}};
   endtask

   initial begin
      set_rst(1'b1);
      {CEA1, CEA2, CEB1, CEB2, CEC, CED, CEAD, CEM, CEP, CECTRL, CEALUMODE, CECARRYIN, CEINMODE} = '1;
      A = '0; B = '0; C = '0; D = '0; ACIN = '0; BCIN = '0; PIN = '0;
      CARRYCASCIN = 1'b0; MULTSIGNIN = 1'b0; CARRYIN = 1'b0;
      INMODE = '0; OPMODE = '0; ALUMODE = '0; CARRYINSEL = '0;

      // Reset state
      step(2);
      chk("rst_p", P, 48'h0);
      chk("rst_pd", PATTERN_DETECT, 48'h0);
      chk("rst_pdb", PATTERNB_DETECT, 48'h0);
      chk("rst_carry", CARRYOUT, 48'h0);
      chk("rst_acout", ACOUT, 48'h0);
      set_rst(1'b0);
      step(1);

      // {A,B}+C
      A = 30'd2; B = 18'd3; C = 48'd4; OPMODE = 7'b0001111; ALUMODE = 4'b0000;
      step(3);
      chk("abc_p", P, 48'h80007);
      chk("abc_pcout", PCOUT, 48'h80007);
      chk("abc_acout", ACOUT, 48'd2);
      chk("abc_bcout", BCOUT, 48'd3);

      // C path latency: two edges to P
      C = 48'd5;
      step(1);
      chk("lat_c_e1", P, 48'h80007);
      step(1);
      chk("lat_c_e2", P, 48'h80008);

      // Multiply
      A = 30'd2; B = 18'd3; OPMODE = 7'b0000101;
      step(5);
      chk("mul_2x3", P, 48'd6);
      chk("mul_sign_pos", MULTSIGNOUT, 48'd0);
      A = 30'h3FFF_FFFE; B = 18'h3FFFC;
      step(5);
      chk("mul_m2xm4", P, 48'd8);
      B = 18'd4;
      step(5);
      chk("mul_m2x4", P, 48'hFFFF_FFFF_FFF8);
      chk("mul_sign_neg", MULTSIGNOUT, 48'd1);

      // Pre-adder
      A = 30'd3; B = 18'd2; D = 25'd10; INMODE = 5'b00100;
      step(5);
      chk("pre_dpa", P, 48'd26);
      INMODE = 5'b01100;
      step(5);
      chk("pre_dma", P, 48'd14);
      INMODE = 5'b00110;
      step(5);
      chk("pre_azero", P, 48'd20);
      INMODE = 5'b00000;

      // {A,B} xor C
      A = 30'd2; B = 18'd4; C = 48'd7; OPMODE = 7'b0110011; ALUMODE = 4'b0100;
      step(3);
      chk("xor_p", P, 48'h80003);

      // Pattern detect against C
      C = 48'h80004; OPMODE = 7'b0000011; ALUMODE = 4'b0000;
      step(3);
      chk("pat_p", P, 48'h80004);
      chk("pat_pd", PATTERN_DETECT, 48'd1);
      chk("pat_pdb", PATTERNB_DETECT, 48'd0);

      C = 48'd0; OPMODE = 7'b0001000;
      step(3);
      chk("patb_p", P, 48'hFFFF_FFFF_FFFF);
      chk("patb_pdb", PATTERNB_DETECT, 48'd1);
      chk("patb_pd", PATTERN_DETECT, 48'd0);

      // Carry out of the 48-bit adder
      A = 30'h3FFF_FFFF; B = 18'h3FFFF; C = 48'd1; OPMODE = 7'b0001111;
      step(3);
      chk("cy_p", P, 48'd0);
      chk("cy_out", CARRYOUT, 48'd1);
      chk("cy_casc", CARRYCASCOUT, 48'd1);

      // Z-(X+Y+CIN) and -Z+X+Y+CIN-1
      A = 30'd0; B = 18'd5; C = 48'h10_0000; OPMODE = 7'b0110011; ALUMODE = 4'b0011;
      step(3);
      chk("zsub", P, 48'hF_FFFB);
      C = 48'd3; ALUMODE = 4'b0001;
      step(3);
      chk("nzadd", P, 48'd1);
      CARRYIN = 1'b1;
      step(3);
      chk("nzadd_cin", P, 48'd2);
      CARRYIN = 1'b0;

      // Logic AND
      A = 30'd2; B = 18'd4; C = 48'h80006; ALUMODE = 4'b1100;
      step(3);
      chk("and_p", P, 48'h80004);

      // PIN arithmetic shift through Z
      PIN = 48'h8000_0000_0000; OPMODE = 7'b1010000; ALUMODE = 4'b0000;
      step(3);
      chk("pin_shift", P, 48'hFFFF_C000_0000);

      // CEP hold, async RSTP, then accumulate P += M
      CEP = 1'b0; A = 30'd3; B = 18'd5; OPMODE = 7'b0100101;
      step(5);
      chk("cep_hold", P, 48'hFFFF_C000_0000);
      RSTP = 1'b1;
      #1;
      chk("rstp_async", P, 48'd0);
      RSTP = 1'b0; CEP = 1'b1;
      step(1);
      chk("acc_1", P, 48'd15);
      step(2);
      chk("acc_3", P, 48'd45);
      CEP = 1'b0; A = 30'd7;
      step(3);
      chk("acc_frozen", P, 48'd45);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
